// File: rtl/medfilt_pkg.sv
// Shared widths, packed-word type and helpers for the median-filter output packer.
package medfilt_pkg;

  localparam int PIX_W  = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = PIX_W * LANES;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } pack_word_t;

  function automatic int fifo_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [PIX_W-1:0] clip_pix(input logic [PIX_W-1:0] pix,
                                                input logic             en,
                                                input logic [PIX_W-1:0] max_val);
    if (en && (pix > max_val)) begin
      return max_val;
    end else begin
      return pix;
    end
  endfunction

endpackage

// File: rtl/medfilt_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write on a full FIFO is accepted
// only together with a read. flush empties it, keeping a same-cycle write.
module medfilt_sync_fifo
  import medfilt_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = fifo_aw(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_idx;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    rd_ok   = rd_en & ~empty;
    wr_ok   = wr_en & (~full | rd_en);
    mem_we  = flush ? wr_en : wr_ok;
    mem_idx = flush ? '0 : wr_ptr;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= wr_en ? AW'(1) : '0;
      count  <= wr_en ? (AW+1)'(1) : '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/medfilt_out_packer.sv
// Packs filtered pixel pairs into 64-bit words with end-of-row marking and a
// FWFT output FIFO. Define MEDFILT_PACK_CLIP_EN to saturate pixels to CLIP_MAX.
module medfilt_out_packer
  import medfilt_pkg::*;
#(
  parameter int ROW_PIX    = 512,
  parameter int FIFO_DEPTH = 8,
  parameter int CLIP_MAX   = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [15:0] medfilt_data_out,
  input  logic [15:0] medfilt_data_out2,
  input  logic        medfilt_done_flag,
  output logic [63:0] pack_data,
  output logic        pack_valid,
  input  logic        pack_ready,
  output logic        pack_last,
  output logic        ovf_flag,
  output logic [15:0] row_cnt
);

`ifdef MEDFILT_PACK_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif
  localparam logic [PIX_W-1:0] CLIP_VAL = PIX_W'(CLIP_MAX);
  localparam logic [15:0]      ROW_END  = 16'(ROW_PIX);
  localparam int               FW       = $bits(pack_word_t);

  logic [2*PIX_W-1:0] held;
  logic               half_full;
  logic [15:0]        col_cnt;

  logic [PIX_W-1:0]   px0;
  logic [PIX_W-1:0]   px1;
  logic               half_base;
  logic [15:0]        col_base;
  logic               row_end;
  logic               push;
  logic               drop;
  pack_word_t         wr_word;
  pack_word_t         head;
  logic [FW-1:0]      fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;

  // frame_start rewinds packing state so a same-cycle pair opens the new frame
  always_comb begin
    px0       = clip_pix(medfilt_data_out,  CLIP_EN, CLIP_VAL);
    px1       = clip_pix(medfilt_data_out2, CLIP_EN, CLIP_VAL);
    half_base = half_full & ~frame_start;
    col_base  = frame_start ? 16'd0 : col_cnt;
    row_end   = medfilt_done_flag & ((col_base + 16'd2) == ROW_END);
    push      = medfilt_done_flag & (half_base | row_end);
    wr_word.last = row_end;
    if (half_base) begin
      wr_word.data = {px1, px0, held};
    end else begin
      wr_word.data = {32'd0, px1, px0};
    end
    drop = push & fifo_full & ~pack_ready & ~frame_start;
    head = pack_word_t'(fifo_dout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held      <= '0;
      half_full <= 1'b0;
      col_cnt   <= 16'd0;
      row_cnt   <= 16'd0;
      ovf_flag  <= 1'b0;
    end else begin
      ovf_flag <= frame_start ? 1'b0 : (ovf_flag | drop);
      if (medfilt_done_flag) begin
        if (!half_base) begin
          held <= {px1, px0};
        end
        // counters advance even when the word is dropped, keeping row alignment
        if (row_end) begin
          col_cnt   <= 16'd0;
          half_full <= 1'b0;
          row_cnt   <= (frame_start ? 16'd0 : row_cnt) + 16'd1;
        end else begin
          col_cnt   <= col_base + 16'd2;
          half_full <= ~half_base;
          row_cnt   <= frame_start ? 16'd0 : row_cnt;
        end
      end else if (frame_start) begin
        col_cnt   <= 16'd0;
        half_full <= 1'b0;
        row_cnt   <= 16'd0;
      end else begin
        col_cnt   <= col_cnt;
        half_full <= half_full;
        row_cnt   <= row_cnt;
      end
    end
  end

  medfilt_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .wr_en (push),
    .din   (wr_word),
    .rd_en (pack_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    pack_valid = ~fifo_empty;
    pack_data  = fifo_empty ? 64'd0 : head.data;
    pack_last  = ~fifo_empty & head.last;
  end

endmodule
